score_display_mux: RTL and testbench

Drives the board's 4-digit common-anode seven-segment display with both players' scores: left score on the two left digits, right score on the two right digits. It sits on the output side of the user I/O, opposite the button debouncers, and is fed by the game logic's score registers. The block provides time-multiplexed digit scanning, binary-to-BCD conversion, leading-zero blanking, anti-ghosting blank windows and a per-side blink when a score changes.

---
 rtl/score_display_mux_if.sv | 11 +
 rtl/score_display_mux.sv | 179 +++++++++++++++++
 tb/tb_score_display_mux.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_display_mux_if.sv
// Score inputs and seven-segment display outputs of score_display_mux.
interface score_display_mux_if;
  logic [6:0] score_l;
  logic [6:0] score_r;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output score_l, output score_r, input an, input seg, input dp);
  modport slave  (input score_l, input score_r, output an, output seg, output dp);
endinterface

// File: rtl/score_display_mux.sv
// Four-digit multiplexed score display: clamp, BCD convert, scan with blank windows,
// leading-zero blanking and a per-side blink whenever a score changes.
module score_display_mux #(
  parameter int unsigned DIGIT_CYCLES = 65000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned BLINK_HALF   = 16250000
) (
  input logic                clk,
  input logic                rst,
  score_display_mux_if.slave disp
);

  localparam int unsigned SLOT_W  = $clog2(DIGIT_CYCLES);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]  SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [2:0]         LAST_PHASE = 3'd5;

  typedef enum logic {IDLE, BLINK} blink_state_e;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Stage 1: clamped input registers; a differing clamped sample marks a change.
  logic [6:0] cl_l_c, cl_r_c, sc_l, sc_r;
  logic [1:0] chg_c;

  assign cl_l_c = clamp99(disp.score_l);
  assign cl_r_c = clamp99(disp.score_r);
  assign chg_c  = {cl_l_c != sc_l, cl_r_c != sc_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_l <= '0;
      sc_r <= '0;
    end else begin
      sc_l <= cl_l_c;
      sc_r <= cl_r_c;
    end
  end

  // Stage 2: BCD registers (inputs are already limited to 0..99).
  logic [3:0] tens_l, units_l, tens_r, units_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_l  <= '0;
      units_l <= '0;
      tens_r  <= '0;
      units_r <= '0;
    end else begin
      tens_l  <= 4'(sc_l / 7'd10);
      units_l <= 4'(sc_l % 7'd10);
      tens_r  <= 4'(sc_r / 7'd10);
      units_r <= 4'(sc_r % 7'd10);
    end
  end

  // Blink FSMs, index 1 = left side, index 0 = right side.
  blink_state_e       st_q [2];
  blink_state_e       st_d [2];
  logic [2:0]         ph_q [2];
  logic [2:0]         ph_d [2];
  logic [BLINK_W-1:0] bc_q [2];
  logic [BLINK_W-1:0] bc_d [2];
  logic [1:0]         dark_c;

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        st_q[s] <= IDLE;
        ph_q[s] <= '0;
        bc_q[s] <= '0;
      end else begin
        st_q[s] <= st_d[s];
        ph_q[s] <= ph_d[s];
        bc_q[s] <= bc_d[s];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      st_d[s]   = st_q[s];
      ph_d[s]   = ph_q[s];
      bc_d[s]   = bc_q[s];
      dark_c[s] = (st_q[s] == BLINK) && !ph_q[s][0];
      if (chg_c[s]) begin
        st_d[s] = BLINK;
        ph_d[s] = '0;
        bc_d[s] = '0;
      end else if (st_q[s] == BLINK) begin
        if (bc_q[s] == BLINK_LAST) begin
          bc_d[s] = '0;
          if (ph_q[s] == LAST_PHASE) begin
            st_d[s] = IDLE;
            ph_d[s] = '0;
          end else begin
            ph_d[s] = ph_q[s] + 3'd1;
          end
        end else begin
          bc_d[s] = bc_q[s] + BLINK_W'(1);
        end
      end
    end
  end

  // Scan: slot counter within a digit, digit index advances on slot wrap.
  logic [SLOT_W-1:0] slot;
  logic [1:0]        idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      idx  <= '0;
    end else if (slot == SLOT_LAST) begin
      slot <= '0;
      idx  <= idx + 2'd1;
    end else begin
      slot <= slot + SLOT_W'(1);
    end
  end

  // Stage 3 decode: idx[1] picks the side, idx[0] picks tens over units.
  logic [3:0] digit_c;
  logic [3:0] an_c;
  logic [6:0] seg_c;
  logic       dp_c;

  always_comb begin
    an_c  = 4'hF;
    seg_c = 7'h7F;
    dp_c  = 1'b1;
    case (idx)
      2'd0:    digit_c = units_r;
      2'd1:    digit_c = tens_r;
      2'd2:    digit_c = units_l;
      default: digit_c = tens_l;
    endcase
    if (slot >= SLOT_BLANK && !dark_c[idx[1]]) begin
      an_c  = ~(4'b0001 << idx);
      seg_c = (idx[0] && digit_c == 4'd0) ? 7'h7F : seg_code(digit_c);
      dp_c  = (idx != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp.an  <= 4'hF;
      disp.seg <= 7'h7F;
      disp.dp  <= 1'b1;
    end else begin
      disp.an  <= an_c;
      disp.seg <= seg_c;
      disp.dp  <= dp_c;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Bench for score_display_mux: arithmetic reference model checked every cycle, a table of
// static display vectors, and hand sequences for blink, restart, clamp and mid-scan reset.
module tb_score_display_mux;

  localparam int DIG = 8;
  localparam int BLK = 2;
  localparam int BH  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_display_mux_if bus ();

  score_display_mux #(
    .DIGIT_CYCLES(DIG),
    .BLANK_CYCLES(BLK),
    .BLINK_HALF  (BH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .disp(bus)
  );

  typedef struct {
    int         sl;
    int         sr;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t       vt [17];
  logic [6:0] seg_tab [10];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  // Reference model state: edges since reset release, sampled scores, edge of last change.
  int         n, now_l, now_r, old_l, old_r, chg_l, chg_r;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  function automatic int clamp(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  // Expected outputs after this edge come from the scan position, the score sampled two
  // edges earlier and the time elapsed since that side's last change.
  task automatic model_step(input logic r, input int sl, input int sr);
    int p, slot, dig, val, d, m, chg;
    logic [3:0] one;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (r) begin
      n = 0; now_l = 0; now_r = 0; old_l = 0; old_r = 0;
      chg_l = -1000000; chg_r = -1000000;
      return;
    end
    p    = n;
    slot = p % DIG;
    dig  = (p / DIG) % 4;
    val  = (dig >= 2) ? old_l : old_r;
    chg  = (dig >= 2) ? chg_l : chg_r;
    m    = p - 1 - chg;
    if (slot >= BLK && !(m >= 0 && m < 6 * BH && ((m / BH) % 2) == 0)) begin
      d     = (dig % 2 == 1) ? val / 10 : val % 10;
      one   = 4'b0001 << dig;
      e_an  = ~one;
      e_seg = (dig % 2 == 1 && d == 0) ? 7'h7F : seg_tab[d];
      e_dp  = (dig == 2) ? 1'b0 : 1'b1;
    end
    if (clamp(sl) != now_l) chg_l = p;
    if (clamp(sr) != now_r) chg_r = p;
    old_l = now_l;
    old_r = now_r;
    now_l = clamp(sl);
    now_r = clamp(sr);
    n     = p + 1;
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: advance the model at the edge, compare all outputs on the falling edge.
  task automatic cyc(input string name);
    @(posedge clk);
    model_step(rst, int'(bus.score_l), int'(bus.score_r));
    @(negedge clk);
    total_cnt++;
    if (bus.an === e_an && bus.seg === e_seg && bus.dp === e_dp) pass_cnt++;
    else $display("FAIL %s: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b (t=%0t)",
                  name, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp, $time);
  endtask

  function automatic int lit_l();
    return (bus.an[3:2] != 2'b11) ? 1 : 0;
  endfunction

  function automatic int lit_r();
    return (bus.an[1:0] != 2'b11) ? 1 : 0;
  endfunction

  task automatic set_scores(input int sl, input int sr);
    bus.score_l = 7'(sl);
    bus.score_r = 7'(sr);
  endtask

  initial begin
    int cl, cr, dl, found;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    vt[0]  = '{7,   42, 4'hE, 7'h24, 1'b1};
    vt[1]  = '{7,   42, 4'hD, 7'h19, 1'b1};
    vt[2]  = '{7,   42, 4'hB, 7'h78, 1'b0};
    vt[3]  = '{7,   42, 4'h7, 7'h7F, 1'b1};
    vt[4]  = '{127, 42, 4'h7, 7'h10, 1'b1};
    vt[5]  = '{127, 42, 4'hB, 7'h10, 1'b0};
    vt[6]  = '{100, 0,  4'h7, 7'h10, 1'b1};
    vt[7]  = '{100, 0,  4'hE, 7'h40, 1'b1};
    vt[8]  = '{100, 0,  4'hD, 7'h7F, 1'b1};
    vt[9]  = '{58,  90, 4'h7, 7'h12, 1'b1};
    vt[10] = '{58,  90, 4'hB, 7'h00, 1'b0};
    vt[11] = '{58,  90, 4'hD, 7'h10, 1'b1};
    vt[12] = '{58,  90, 4'hE, 7'h40, 1'b1};
    vt[13] = '{31,  66, 4'h7, 7'h30, 1'b1};
    vt[14] = '{31,  66, 4'hB, 7'h79, 1'b0};
    vt[15] = '{31,  66, 4'hD, 7'h02, 1'b1};
    vt[16] = '{31,  66, 4'hE, 7'h02, 1'b1};

    // Reset and first scan with zero scores.
    rst = 1'b1;
    set_scores(0, 0);
    repeat (3) cyc("reset");
    chk_int("reset_an", int'(bus.an), 'hF);
    rst = 1'b0;
    repeat (2) cyc("first_blank");
    chk_int("first_blank_an", int'(bus.an), 'hF);
    cyc("first_digit");
    chk_int("first_digit_an", int'(bus.an), 'hE);
    chk_int("first_digit_seg", int'(bus.seg), 'h40);
    repeat (40) cyc("scan_zero");

    // Table of static displays, each checked once its blinks have finished.
    cl = 0; cr = 0;
    foreach (vt[i]) begin
      if (vt[i].sl != cl || vt[i].sr != cr) begin
        set_scores(vt[i].sl, vt[i].sr);
        cl = vt[i].sl; cr = vt[i].sr;
        repeat (110) cyc("table_settle");
      end
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
        cyc("table_hunt");
        if (bus.an == vt[i].an) begin
          found = 1;
          chk_int("table_seg", int'(bus.seg), int'(vt[i].seg));
          chk_int("table_dp", int'(bus.dp), int'(vt[i].dp));
        end
      end
      chk_int("table_digit_seen", found, 1);
    end

    // Single-side blink: right changes 3 -> 4, left stays lit.
    set_scores(7, 3);
    repeat (110) cyc("blink_settle");
    set_scores(7, 4);
    dl = 0; found = 0; cl = 0;
    for (int k = 1; k <= 129; k++) begin
      cyc("blink");
      if ((k >= 2 && k <= 17) || (k >= 34 && k <= 49) || (k >= 66 && k <= 81)) dl += lit_r();
      if (k >= 2 && k <= 33) cl += lit_l();
      if (k >= 98) found += lit_r();
    end
    chk_int("blink_dark_right", dl, 0);
    chk_int("blink_left_unaffected", cl, 12);
    chk_int("blink_right_steady_after", found, 12);

    // Simultaneous change, then a right restart during its phase 3.
    set_scores(12, 34);
    dl = 0; cl = 0;
    for (int k = 1; k <= 140; k++) begin
      if (k == 50) set_scores(12, 35);
      cyc("restart");
      if (k >= 66 && k <= 81) dl += lit_l();
      if (k >= 115 && k <= 130) cl += lit_r();
    end
    chk_int("restart_left_phase4_dark", dl, 0);
    chk_int("restart_right_phase4_dark", cl, 0);

    // Mid-scan reset during digit 2 while the right side is still blinking.
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if ((n / DIG) % 4 == 2 && n % DIG == 4) found = 1;
      else cyc("reset_hunt");
    end
    chk_int("reset_hunt_done", found, 1);
    rst = 1'b1;
    cyc("mid_reset");
    chk_int("mid_reset_an", int'(bus.an), 'hF);
    chk_int("mid_reset_seg", int'(bus.seg), 'h7F);
    chk_int("mid_reset_dp", int'(bus.dp), 1);
    rst = 1'b0;
    repeat (120) cyc("post_reset");

    // Clamp: 127 -> 100 stays at 99, so left keeps its full scan share.
    set_scores(127, 35);
    repeat (110) cyc("clamp_settle");
    set_scores(100, 35);
    cl = 0;
    for (int k = 1; k <= 33; k++) begin
      cyc("clamp_hold");
      if (k >= 2) cl += lit_l();
    end
    chk_int("clamp_no_blink", cl, 12);

    // Randomized stimulus with occasional resets, biased toward the clamp region.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(59, 0) == 0)
        bus.score_l = 7'(($urandom_range(1, 0) == 0) ? $urandom_range(127, 0) : $urandom_range(127, 95));
      if ($urandom_range(59, 0) == 0)
        bus.score_r = 7'(($urandom_range(1, 0) == 0) ? $urandom_range(127, 0) : $urandom_range(127, 95));
      if ($urandom_range(99, 0) == 0) bus.score_r = bus.score_l;
      rst = ($urandom_range(399, 0) == 0) ? 1'b1 : 1'b0;
      cyc("random");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
